// File: rtl/trax_pkg.sv
// Shared Trax move definitions: tile codes, move-word field positions and the
// ASCII alphabet used on the serial link by both the move sender and receiver.
package trax_pkg;

    typedef enum logic [1:0] {
        TILE_NONE   = 2'b00,
        TILE_PLUS   = 2'b01,
        TILE_SLASH  = 2'b10,
        TILE_BSLASH = 2'b11
    } tile_e;

    localparam int MOVE_W  = 22;
    localparam int TILE_HI = 21;
    localparam int TILE_LO = 20;
    localparam int COL_HI  = 19;
    localparam int COL_LO  = 10;
    localparam int ROW_HI  = 9;
    localparam int ROW_LO  = 0;

    localparam logic [9:0] MAX_COL = 10'd26;
    localparam logic [9:0] MAX_ROW = 10'd999;

    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_SLASH  = 8'h2F;
    localparam logic [7:0] ASCII_BSLASH = 8'h5C;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    // Column char, up to three row digits, tile char, LF.
    localparam int MAX_MOVE_BYTES = 6;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_phase_e;

    function automatic logic [7:0] tile_char(input tile_e tile);
        case (tile)
            TILE_SLASH:  return ASCII_SLASH;
            TILE_BSLASH: return ASCII_BSLASH;
            default:     return ASCII_PLUS;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be loaded while idle or in the last cycle
// of the stop bit, so consecutive bytes follow each other with no idle gap.
module uart_tx_byte
    import trax_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434  // must be at least 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       phase_end_o,
    output logic       stop_near_o,
    output logic       tx_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_NEAR = CW'(CLKS_PER_BIT - 3);

    uart_phase_e   phase_q, phase_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_last;

    assign baud_last   = (baud_q == BAUD_LAST);
    assign ready_o     = (phase_q == UART_IDLE) || ((phase_q == UART_STOP) && baud_last);
    assign phase_end_o = baud_last && (phase_q != UART_IDLE) &&
                         ((phase_q != UART_DATA) || (bit_q == 3'd7));
    // Lets the sequencer run NEXT and LOAD inside the stop bit of a middle byte.
    assign stop_near_o = (phase_q == UART_STOP) && (baud_q == BAUD_NEAR);

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        case (phase_q)
            UART_IDLE: begin
                baud_d = '0;
                if (load_i) begin
                    phase_d = UART_START;
                    shift_d = data_i;
                end
            end
            UART_START: begin
                if (baud_last) begin
                    phase_d = UART_DATA;
                    bit_d   = 3'd0;
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) phase_d = UART_STOP;
                end
            end
            UART_STOP: begin
                if (baud_last) begin
                    if (load_i) begin
                        phase_d = UART_START;
                        shift_d = data_i;
                    end else begin
                        phase_d = UART_IDLE;
                    end
                end
            end
            default: phase_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'hFF;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        case (phase_q)
            UART_START: tx_o = 1'b0;
            UART_DATA:  tx_o = shift_q[0];
            default:    tx_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/trax_move_tx.sv
// Trax move sender: validates a move word, renders it as ASCII text
// (column, decimal row, tile, LF) and streams the bytes over a UART.
module trax_move_tx
    import trax_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MOVE_W-1:0] move,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tx
);

    typedef enum logic [3:0] {
        IDLE, CHECK, CONVERT, LOAD, START, DATA, STOP, NEXT, FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [MOVE_W-1:0] move_q, move_d;
    logic [9:0]        rem_q, rem_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        tens_q, tens_d;
    logic [2:0]        count_q, count_d;
    logic [2:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic [MAX_MOVE_BYTES-1:0][7:0] bytes_q, bytes_d;

    tile_e      mv_tile;
    logic [9:0] mv_col, mv_row;
    logic       move_invalid, last_byte;
    logic [2:0] fill;
    logic       uart_load, uart_ready, uart_phase_end, uart_stop_near;

    assign mv_tile      = tile_e'(move_q[TILE_HI:TILE_LO]);
    assign mv_col       = move_q[COL_HI:COL_LO];
    assign mv_row       = move_q[ROW_HI:ROW_LO];
    assign move_invalid = (mv_tile == TILE_NONE) || (mv_col > MAX_COL) || (mv_row > MAX_ROW);
    assign last_byte    = (idx_q == count_q - 3'd1);

    always_comb begin
        state_d   = state_q;
        move_d    = move_q;
        rem_d     = rem_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        count_d   = count_q;
        idx_d     = idx_q;
        bytes_d   = bytes_q;
        err_d     = 1'b0;
        uart_load = 1'b0;
        fill      = 3'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    move_d  = move;
                    idx_d   = 3'd0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (move_invalid) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    rem_d   = mv_row;
                    hund_d  = 4'd0;
                    tens_d  = 4'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (rem_q >= 10'd100) begin
                    rem_d  = rem_q - 10'd100;
                    hund_d = hund_q + 4'd1;
                end else if (rem_q >= 10'd10) begin
                    rem_d  = rem_q - 10'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    // Remainder is the units digit; pack the text, skipping leading zeros.
                    bytes_d[0] = ASCII_AT + 8'(mv_col);
                    fill       = 3'd1;
                    if (hund_q != 4'd0) begin
                        bytes_d[fill] = ASCII_ZERO + 8'(hund_q);
                        fill          = fill + 3'd1;
                    end
                    if ((hund_q != 4'd0) || (tens_q != 4'd0)) begin
                        bytes_d[fill] = ASCII_ZERO + 8'(tens_q);
                        fill          = fill + 3'd1;
                    end
                    bytes_d[fill] = ASCII_ZERO + 8'(rem_q);
                    fill          = fill + 3'd1;
                    bytes_d[fill] = tile_char(mv_tile);
                    fill          = fill + 3'd1;
                    bytes_d[fill] = ASCII_LF;
                    count_d       = fill + 3'd1;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                uart_load = 1'b1;
                if (uart_ready) state_d = START;
            end
            START: if (uart_phase_end) state_d = DATA;
            DATA:  if (uart_phase_end) state_d = STOP;
            STOP: begin
                // The final stop bit runs to completion before done is reported.
                if (last_byte ? uart_phase_end : uart_stop_near) state_d = NEXT;
            end
            NEXT: begin
                if (last_byte) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOAD;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            move_q  <= '0;
            rem_q   <= '0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            count_q <= 3'd0;
            idx_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            rem_q   <= rem_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the byte buffer is not reset; it is always rewritten in CONVERT before any byte is read.
    always_ff @(posedge clk) begin
        bytes_q <= bytes_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk        (clk),
        .reset      (reset),
        .load_i     (uart_load),
        .data_i     (bytes_q[idx_q]),
        .ready_o    (uart_ready),
        .phase_end_o(uart_phase_end),
        .stop_near_o(uart_stop_near),
        .tx_o       (tx)
    );

    assign busy = (state_q != IDLE) && (state_q != FINISH);
    assign done = (state_q == FINISH);
    assign err  = err_q;

endmodule
